// File: rtl/m_progloader_if.sv
// Memory write port driven by the program loader: one word per r_we pulse.
interface m_progloader_if;
  logic [11:0] r_addr;
  logic [31:0] r_din;
  logic        r_we;

  modport master (output r_addr, output r_din, output r_we);
  modport slave  (input  r_addr, input  r_din, input  r_we);
endinterface

// File: rtl/m_progloader.sv
// UART program loader: receives a word-count-prefixed frame of little-endian
// 32-bit words over 8N1 serial and writes them into the target memory.
module m_progloader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAXWORDS     = 4096
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  input  logic            w_rxd,
  m_progloader_if.master  mem,
  output logic            r_hold,
  output logic            r_done,
  output logic            r_err
);

  localparam int              CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]     MAX_W  = 17'(MAXWORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {LD_IDLE, LD_CNT_HI, LD_DATA, LD_DONE} ld_state_e;

  // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detection.
  logic [2:0]  sync_q, sync_d;
  rx_state_e   rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        byte_vld_q, byte_vld_d;
  logic        frame_err_q, frame_err_d;

  ld_state_e   ld_q, ld_d;
  logic [15:0] n_q, n_d;
  logic [12:0] widx_q, widx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] din_q, din_d;
  logic [11:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] n_full;

  wire rxd_s    = sync_q[1];
  wire rxd_prev = sync_q[2];

  // NOTE: every always_comb output gets its default first so no path can infer a latch.
  always_comb begin
    sync_d      = {sync_q[1:0], w_rxd};
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_d      = byte_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_q)
      RX_IDLE: begin
        if (rxd_prev && !rxd_s) begin
          rx_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == C_HALF) begin
          cnt_d = '0;
          bit_d = '0;
          rx_d  = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == C_FULL) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == C_FULL) begin
          cnt_d = '0;
          rx_d  = RX_IDLE;
          if (rxd_s) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  always_comb begin
    ld_d   = ld_q;
    n_d    = n_q;
    widx_d = widx_q;
    bidx_d = bidx_q;
    din_d  = din_q;
    addr_d = addr_q;
    we_d   = 1'b0;
    hold_d = hold_q;
    done_d = done_q;
    err_d  = err_q | frame_err_q;
    n_full = {byte_q, n_q[7:0]};
    case (ld_q)
      LD_IDLE, LD_DONE: begin
        if (byte_vld_q) begin
          n_d[7:0] = byte_q;
          done_d   = 1'b0;
          hold_d   = 1'b1;
          ld_d     = LD_CNT_HI;
        end
      end
      LD_CNT_HI: begin
        if (frame_err_q) begin
          ld_d = LD_IDLE;
        end else if (byte_vld_q) begin
          n_d = n_full;
          if (n_full == 16'd0) begin
            ld_d   = LD_DONE;
            done_d = 1'b1;
            hold_d = 1'b0;
          end else if ({1'b0, n_full} > MAX_W) begin
            err_d = 1'b1;
            ld_d  = LD_IDLE;
          end else begin
            ld_d   = LD_DATA;
            widx_d = '0;
            bidx_d = '0;
          end
        end
      end
      LD_DATA: begin
        if (frame_err_q) begin
          ld_d = LD_IDLE;
        end else if (we_q && ({3'b000, widx_q} == n_q)) begin
          // The last word's write pulse has just been presented.
          ld_d   = LD_DONE;
          done_d = 1'b1;
          hold_d = 1'b0;
        end else if (byte_vld_q) begin
          din_d[{bidx_q, 3'b000} +: 8] = byte_q;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = widx_q[11:0];
            widx_d = widx_q + 13'd1;
          end
        end
      end
      default: ld_d = LD_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      sync_q      <= 3'b111;
      rx_q        <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ld_q        <= LD_IDLE;
      n_q         <= '0;
      widx_q      <= '0;
      bidx_q      <= '0;
      din_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      ld_q        <= ld_d;
      n_q         <= n_d;
      widx_q      <= widx_d;
      bidx_q      <= bidx_d;
      din_q       <= din_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem.r_addr = addr_q;
  assign mem.r_din  = din_q;
  assign mem.r_we   = we_q;
  assign r_hold     = hold_q;
  assign r_done     = done_q;
  assign r_err      = err_q;

endmodule

// File: tb/tb_m_progloader.sv
// Self-checking bench for m_progloader: serial frames are driven bit by bit and
// the memory writes and status flags are compared against a frame-level model.
module tb_m_progloader;
  localparam int CPB  = 4;
  localparam int MAXW = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;
  logic hold, done, err;

  m_progloader_if mem_if ();

  m_progloader #(.CLKS_PER_BIT(CPB), .MAXWORDS(MAXW)) dut (
    .w_clk   (clk),
    .w_rst_n (rst_n),
    .w_rxd   (rxd),
    .mem     (mem_if.master),
    .r_hold  (hold),
    .r_done  (done),
    .r_err   (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected and observed writes, each {addr[11:0], data[31:0]}.
  logic [43:0] exp_q[$];
  logic [43:0] obs_q[$];
  logic m_done = 1'b0, m_hold = 1'b1, m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Per-cycle checks of the write port and the sticky error flag.
  logic        prev_we   = 1'b0;
  logic        prev_err  = 1'b0;
  logic [11:0] prev_addr = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_if.r_we) begin
        obs_q.push_back({mem_if.r_addr, mem_if.r_din});
        if (exp_q.size() == 0) begin
          check("unexpected_we", 32'd1, 32'd0);
        end else begin
          check("we_addr", {20'd0, mem_if.r_addr}, {20'd0, exp_q[0][43:32]});
          check("we_data", mem_if.r_din, exp_q[0][31:0]);
          void'(exp_q.pop_front());
        end
      end else begin
        check("addr_hold", {20'd0, mem_if.r_addr}, {20'd0, prev_addr});
      end
      check("we_back_to_back", {31'd0, prev_we & mem_if.r_we}, 32'd0);
      check("err_sticky", {31'd0, prev_err & ~err}, 32'd0);
    end
    prev_we   <= mem_if.r_we;
    prev_addr <= mem_if.r_addr;
    prev_err  <= err;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_ok;
    tick(CPB);
    rxd = 1'b1;
    tick(stop_ok ? int'($urandom_range(0, 3)) : 2);
  endtask

  task automatic build_frame(input int n, output logic [7:0] fr[$]);
    fr = {};
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) fr.push_back(8'($urandom));
  endtask

  task automatic check_status(input string tag);
    check({tag, "_done"}, {31'd0, done}, {31'd0, m_done});
    check({tag, "_hold"}, {31'd0, hold}, {31'd0, m_hold});
    check({tag, "_err"},  {31'd0, err},  {31'd0, m_err});
    check({tag, "_writes_pending"}, exp_q.size(), 32'd0);
  endtask

  // Frame-level model: the byte at index bad (if >= 0) gets a 0 stop bit and the
  // frame ends there; only words complete before that byte are written.
  task automatic run_frame(input logic [7:0] fr[$], input int bad);
    int n = int'({fr[1], fr[0]});
    int lim = (bad >= 0) ? bad : fr.size();
    if (bad < 0 && n > MAXW) begin
      m_err = 1'b1; m_hold = 1'b1; m_done = 1'b0;
    end else begin
      for (int i = 0; i < n && (2 + 4 * i + 3) < lim; i++)
        exp_q.push_back({12'(i), fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]});
      if (bad >= 0) begin
        m_err = 1'b1; m_hold = 1'b1; m_done = 1'b0;
      end else begin
        m_hold = 1'b0; m_done = 1'b1;
      end
    end
    for (int j = 0; j < fr.size() && (bad < 0 || j <= bad); j++)
      send_byte(fr[j], j != bad);
    tick(20);
    check_status("frame");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, {20'd0, mem_if.r_addr}, 32'd0);
    check({tag, "_din"},  mem_if.r_din, 32'd0);
    check({tag, "_we"},   {31'd0, mem_if.r_we}, 32'd0);
    check({tag, "_hold"}, {31'd0, hold}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"},  {31'd0, err},  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    int w;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(5);

    // Short low glitch: the start-bit recheck must reject it silently.
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(40);
    check_status("glitch");
    check("glitch_obs", obs_q.size(), 32'd0);

    // Two-word frame with literal expectations on the observed writes.
    obs_q = {};
    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame(fr, -1);
    check("lit_nwrites", obs_q.size(), 32'd2);
    check("lit_w0_addr", {20'd0, obs_q[0][43:32]}, 32'd0);
    check("lit_w0_data", obs_q[0][31:0], 32'h12345678);
    check("lit_w1_addr", {20'd0, obs_q[1][43:32]}, 32'd1);
    check("lit_w1_data", obs_q[1][31:0], 32'hDEADBEEF);

    // Empty frame: done drops on byte 0 and returns right after the second stop bit.
    send_byte(8'h00, 1'b1);
    rxd = 1'b0;
    tick(CPB);
    rxd = 1'b0;
    tick(8 * CPB);
    check("n0_done_cleared", {31'd0, done}, 32'd0);
    check("n0_hold_set", {31'd0, hold}, 32'd1);
    rxd = 1'b1;
    tick(CPB);
    w = 0;
    while (!done && w < 8) begin
      tick(1);
      w++;
    end
    check("n0_done_latency_ok", {31'd0, (w <= 3)}, 32'd1);
    m_done = 1'b1; m_hold = 1'b0;
    tick(20);
    check_status("n0");

    // Reset in the middle of word 1: word 0 stays written, nothing follows.
    build_frame(2, fr);
    exp_q.push_back({12'd0, fr[5], fr[4], fr[3], fr[2]});
    for (int j = 0; j < 8; j++) send_byte(fr[j], 1'b1);
    rxd = 1'b0;
    tick(CPB);
    rxd = fr[8][0];
    tick(3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    check("midframe_word0_written", exp_q.size(), 32'd0);
    rxd = 1'b1;
    tick(2);
    rst_n = 1'b1;
    m_err = 1'b0; m_done = 1'b0; m_hold = 1'b1;
    tick(60);
    check_status("after_reset");
    run_frame(fr, -1);

    // Oversized count, then a valid one-word frame with err still set.
    fr = '{8'h01, 8'h10};
    run_frame(fr, -1);
    build_frame(1, fr);
    run_frame(fr, -1);

    // Bad stop bit on byte 2 of word 0.
    build_frame(1, fr);
    run_frame(fr, 4);

    // Randomized frames, with occasional glitches and framing errors.
    for (int it = 0; it < 12; it++) begin
      int n   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      int bad = -1;
      build_frame(n, fr);
      if ($urandom_range(0, 3) == 0) bad = int'($urandom_range(1, fr.size() - 1));
      if ($urandom_range(0, 2) == 0) begin
        rxd = 1'b0;
        tick(1);
        rxd = 1'b1;
        tick(10);
      end
      run_frame(fr, bad);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
